scan_tile_responder: RTL and testbench
======================================

# scan_tile_responder

Design-side responder for the scan-chain protocol driven by `scan_controller`. It sits between adjacent design slots and oversamples the incoming scan clock, data, select and latch signals on one system clock. It shifts and captures an `NUM_IOS`-bit frame, presents latched inputs to the user design, and forwards the protocol signals, re-timed, to the next tile.

## Interface

Parameters:
- `NUM_IOS`, default 8: frame width, which is the number of design inputs and outputs.
- `SYNC_STAGES`, default 2: synchronizer depth for each incoming scan signal; minimum 2.

Ports:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low, `reset_n`.
- `clk`  in  1  system clock. All logic is in this domain.
- `reset_n`  in  1  asynchronous active-low reset.
- `scan_clk_in`  in  1  upstream scan clock; asynchronous to `clk`.
- `scan_data_in`  in  1  upstream serial data.
- `scan_select_in`  in  1  1 = capture design outputs on the scan-clock rise; 0 = shift.
- `scan_latch_en_in`  in  1  a rising edge transfers the frame to `module_data_in`.
- `scan_clk_out`  out  1  re-timed scan clock to the next tile.
- `scan_data_out`  out  1  serial data to the next tile, taken from the frame MSB.
- `scan_select_out`  out  1  re-timed select.
- `scan_latch_en_out`  out  1  re-timed latch enable.
- `module_data_in`  out  NUM_IOS  latched inputs to the user design.
- `module_data_out`  in  NUM_IOS  outputs from the user design.

## Operation

- Each of the four scan inputs passes through its own `SYNC_STAGES` flop chain. The last stage is registered once more (`_d`) for edge detection: rise = `s & ~s_d`, fall = `~s & s_d`.
- On a scan-clock rise:
  - If the synchronized select is 1, `frame <= module_data_out`.
  - Otherwise, `frame <= {frame[NUM_IOS-2:0], data_s}`.
- On a scan-clock fall: `scan_data_out <= frame[NUM_IOS-1]`.
  - Publishing on the fall keeps the old MSB stable while the downstream tile samples on its own delayed rise.
- On a latch-enable rise: `module_data_in <= frame`.
- Forwarded outputs: `scan_clk_out`, `scan_select_out` and `scan_latch_en_out` equal the `_d` registers of the corresponding synchronized signals.
- There is no FSM beyond the edge detectors. Behaviour is fully defined by the three edge events above.
- Simultaneous events:
  - Scan-clock rise and latch rise in the same cycle: the latch takes the pre-update `frame`.
  - Select changing in the same cycle as a clock rise: the synchronized select value of that cycle decides.
- Reset (asynchronous, at any time, including mid-frame) clears the following to 0:
  - all synchronizer and `_d` flops;
  - `frame`;
  - `module_data_in`;
  - `scan_data_out`, `scan_clk_out`, `scan_select_out`, `scan_latch_en_out`.
- After reset release, a scan clock that is already high causes no edge event. The first event is its next rise.

## Timing

- Input transition to `frame` or `module_data_in` update: `SYNC_STAGES`+1 `clk` rising edges, plus up to 1 cycle of sampling uncertainty.
- Input to forwarded output: the same `SYNC_STAGES`+1 edges, so the relative alignment of clock, select and latch is preserved tile-to-tile.
- `scan_data_out` changes `SYNC_STAGES`+1 edges after a `scan_clk_in` fall.
- Protocol requirement, per tile, for the controller:
  - scan clock high and low phases each ≥ `SYNC_STAGES`+3 `clk` cycles;
  - select and data stable from ≥ `SYNC_STAGES`+2 cycles before the scan-clock rise until the following fall.
- Latch enable may only rise while the scan clock is low and stable.
- Frame of length `NUM_IOS`: `NUM_IOS` shift rises move a full word through one tile. A chain of K tiles needs K·`NUM_IOS` rises.

## Structure

- Shared package `scan_pkg`:
  - `SCAN_NUM_IOS_DEFAULT` = 8;
  - `SCAN_SYNC_STAGES_DEFAULT` = 2;
  - a localparam for the minimum phase, `SYNC_STAGES`+3.
- Sub-module `scan_sync_edge`: a `SYNC_STAGES` flop chain plus a `_d` register, with outputs `sync`, `dly`, `rise`, `fall`.
  - Instantiated four times.
  - Reset to 0 by `reset_n`.
- The top level contains `frame`, `module_data_in`, `scan_data_out` and the forwarding assigns.

## Test plan

Conditions for all scenarios: `NUM_IOS`=8, `SYNC_STAGES`=2, scan clock phase = 8 `clk` cycles.

- Reset: assert `reset_n`=0 mid-shift with `frame`=0xA5 → all outputs 0 within the same cycle. After release, with `scan_clk_in` held high → no shift until the next rise.
- Shift: select=0, shift in 0xC3 MSB-first over 8 rises → `frame`=0xC3. `scan_data_out` emits the previous frame 0x00 bits, each bit appearing 3 `clk` edges after a fall.
- Capture: `module_data_out`=0x5A, select=1, one rise → `frame`=0x5A. Then 8 shift rises → `scan_data_out` sequence 0,1,0,1,1,0,1,0.
- Latch: `frame`=0x3C, latch rise → `module_data_in`=0x3C after 3 edges, and it holds through further shifting. Latch rise coincident with a scan-clock rise → latches the pre-shift value.
- Chain of 2 tiles: shift 16 bits 0xBEEF → tile0 `frame`=0xEF, tile1 `frame`=0xBE. Forwarded clock of tile1 lags `scan_clk_in` by 6 edges.
- Forwarding: toggle select and latch → outputs track with exactly 3-edge latency. No glitch pulses for input pulses ≥ 3 cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants and signal indices for the scan-chain tile responder.
// The minimum scan-clock phase covers the synchronizer, the edge register and one cycle of sampling slack.
package scan_pkg;

  localparam int SCAN_NUM_IOS_DEFAULT     = 8;
  localparam int SCAN_SYNC_STAGES_DEFAULT = 2;
  localparam int SCAN_MIN_PHASE_DEFAULT   = SCAN_SYNC_STAGES_DEFAULT + 3;
  localparam int SCAN_SIG_COUNT           = 4;

  typedef enum logic [1:0] {
    SIG_CLK   = 2'd0,
    SIG_DATA  = 2'd1,
    SIG_SEL   = 2'd2,
    SIG_LATCH = 2'd3
  } scan_sig_e;

  function automatic int scan_min_phase(input int sync_stages);
    return sync_stages + 3;
  endfunction

endpackage

// File: rtl/scan_sync_edge.sv
// Synchronizer chain plus delay register with rise/fall detection for one scan signal.
// Edges are suppressed until the chain has filled after reset, so a level that is already high yields no event.
module scan_sync_edge
  import scan_pkg::*;
#(
  parameter int SYNC_STAGES = SCAN_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic dly,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES:0]   primed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain  <= '0;
      dly    <= 1'b0;
      primed <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], din};
      dly    <= chain[SYNC_STAGES-1];
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = primed[SYNC_STAGES] & sync & ~dly;
  assign fall = primed[SYNC_STAGES] & ~sync & dly;

endmodule

// File: rtl/scan_tile_responder.sv
// Design-side scan-chain responder: oversamples the scan protocol, shifts/captures a frame,
// latches it to the user design and forwards the re-timed protocol signals to the next tile.
module scan_tile_responder
  import scan_pkg::*;
#(
  parameter int NUM_IOS     = SCAN_NUM_IOS_DEFAULT,
  parameter int SYNC_STAGES = SCAN_SYNC_STAGES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scan_clk_in,
  input  logic               scan_data_in,
  input  logic               scan_select_in,
  input  logic               scan_latch_en_in,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select_out,
  output logic               scan_latch_en_out,
  output logic [NUM_IOS-1:0] module_data_in,
  input  logic [NUM_IOS-1:0] module_data_out
);

  logic [SCAN_SIG_COUNT-1:0] scan_in;
  logic [SCAN_SIG_COUNT-1:0] s_sync;
  logic [SCAN_SIG_COUNT-1:0] s_dly;
  logic [SCAN_SIG_COUNT-1:0] s_rise;
  logic [SCAN_SIG_COUNT-1:0] s_fall;
  logic [NUM_IOS-1:0]        frame;
  logic                      edge_unused;

  assign scan_in[SIG_CLK]   = scan_clk_in;
  assign scan_in[SIG_DATA]  = scan_data_in;
  assign scan_in[SIG_SEL]   = scan_select_in;
  assign scan_in[SIG_LATCH] = scan_latch_en_in;

  for (genvar i = 0; i < SCAN_SIG_COUNT; i++) begin : g_sync
    scan_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (scan_in[i]),
      .sync   (s_sync[i]),
      .dly    (s_dly[i]),
      .rise   (s_rise[i]),
      .fall   (s_fall[i])
    );
  end

  // Latch uses the pre-update frame when it coincides with a scan-clock rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame          <= '0;
      module_data_in <= '0;
      scan_data_out  <= 1'b0;
    end else begin
      if (s_rise[SIG_CLK]) begin
        if (s_sync[SIG_SEL]) frame <= module_data_out;
        else                 frame <= {frame[NUM_IOS-2:0], s_sync[SIG_DATA]};
      end
      if (s_fall[SIG_CLK])   scan_data_out  <= frame[NUM_IOS-1];
      if (s_rise[SIG_LATCH]) module_data_in <= frame;
    end
  end

  assign scan_clk_out      = s_dly[SIG_CLK];
  assign scan_select_out   = s_dly[SIG_SEL];
  assign scan_latch_en_out = s_dly[SIG_LATCH];

  assign edge_unused = ^{s_sync[SIG_CLK], s_sync[SIG_LATCH], s_dly[SIG_DATA],
                         s_rise[SIG_DATA], s_rise[SIG_SEL],
                         s_fall[SIG_DATA], s_fall[SIG_SEL], s_fall[SIG_LATCH]};

endmodule

// File: tb/tb_scan_tile_responder.sv
// Self-checking bench for scan_tile_responder: two chained tiles, a reference frame model
// and a queue of expected scan_data_out bits pushed on each scan-clock fall.
module tb_scan_tile_responder;

  localparam int N   = 8;
  localparam int SS  = 2;
  localparam int PH  = 8;
  localparam int LAT = SS + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         scan_clk_in, scan_data_in, scan_select_in, scan_latch_en_in;
  logic         scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out;
  logic [N-1:0] module_data_in, module_data_out;
  logic         t1_clk_out, t1_data_out, t1_select_out, t1_latch_out;
  logic [N-1:0] t1_module_data_in;
  logic [N-1:0] t1_module_data_out;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [N-1:0] model_frame;
  logic [N-1:0] model_latch;
  logic         model_sdo;
  logic         exp_q[$];

  assign t1_module_data_out = '0;

  always #5 clk = ~clk;

  scan_tile_responder #(.NUM_IOS(N), .SYNC_STAGES(SS)) u_tile0 (
    .clk              (clk),
    .reset_n          (reset_n),
    .scan_clk_in      (scan_clk_in),
    .scan_data_in     (scan_data_in),
    .scan_select_in   (scan_select_in),
    .scan_latch_en_in (scan_latch_en_in),
    .scan_clk_out     (scan_clk_out),
    .scan_data_out    (scan_data_out),
    .scan_select_out  (scan_select_out),
    .scan_latch_en_out(scan_latch_en_out),
    .module_data_in   (module_data_in),
    .module_data_out  (module_data_out)
  );

  scan_tile_responder #(.NUM_IOS(N), .SYNC_STAGES(SS)) u_tile1 (
    .clk              (clk),
    .reset_n          (reset_n),
    .scan_clk_in      (scan_clk_out),
    .scan_data_in     (scan_data_out),
    .scan_select_in   (scan_select_out),
    .scan_latch_en_in (scan_latch_en_out),
    .scan_clk_out     (t1_clk_out),
    .scan_data_out    (t1_data_out),
    .scan_select_out  (t1_select_out),
    .scan_latch_en_out(t1_latch_out),
    .module_data_in   (t1_module_data_in),
    .module_data_out  (t1_module_data_out)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n          = 1'b0;
    scan_clk_in      = 1'b0;
    scan_data_in     = 1'b0;
    scan_select_in   = 1'b0;
    scan_latch_en_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n     = 1'b1;
    model_frame = '0;
    model_latch = '0;
    model_sdo   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // One full scan-clock period; returns scan_data_out one edge before and at the expected update.
  task automatic scan_cycle(input logic d, input logic sel, output logic early, output logic late);
    scan_data_in   = d;
    scan_select_in = sel;
    repeat (PH) @(negedge clk);
    scan_clk_in = 1'b1;
    if (sel) model_frame = module_data_out;
    else     model_frame = {model_frame[N-2:0], d};
    repeat (PH) @(negedge clk);
    scan_clk_in = 1'b0;
    exp_q.push_back(model_frame[N-1]);
    repeat (LAT-1) @(posedge clk);
    #1 early = scan_data_out;
    @(posedge clk);
    #1 late = scan_data_out;
    repeat (PH-LAT) @(negedge clk);
  endtask

  task automatic test_reset();
    logic e, l, exp;
    logic [N-1:0] pat;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out, module_data_in} !== '0)
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out, module_data_in});
    else pass_cnt++;
    do_reset();
    pat = 8'hA5;
    for (int i = N-1; i >= 0; i--) begin
      scan_cycle(pat[i], 1'b0, e, l);
      exp = exp_q.pop_front();
      model_sdo = exp;
      check_cnt++;
      if (l !== exp) $display("[TB] FAIL reset_preload_sdo: got %b required %b", l, exp);
      else pass_cnt++;
    end
    scan_latch_en_in = 1'b1;
    model_latch = model_frame;
    repeat (PH) @(negedge clk);
    scan_latch_en_in = 1'b0;
    repeat (PH) @(negedge clk);
    check_cnt++;
    if (module_data_in !== 8'hA5) $display("[TB] FAIL reset_preload_latch: got %h required a5", module_data_in);
    else pass_cnt++;
    scan_data_in = 1'b0;
    repeat (PH) @(negedge clk);
    scan_clk_in = 1'b1;
    repeat (LAT+1) @(posedge clk);
    #1;
    check_cnt++;
    if ({scan_clk_out, scan_data_out} !== 2'b11)
      $display("[TB] FAIL reset_midshift_active: got %b required 11", {scan_clk_out, scan_data_out});
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({u_tile0.frame, module_data_in, scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out} !== '0)
      $display("[TB] FAIL reset_async_clear: got frame %h mdi %h outs %b required all 0", u_tile0.frame,
               module_data_in, {scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out});
    else pass_cnt++;
    @(negedge clk);
    reset_n      = 1'b1;
    scan_data_in = 1'b1;
    model_frame  = '0;
    model_latch  = '0;
    model_sdo    = 1'b0;
    exp_q.delete();
    repeat (2*PH) @(negedge clk);
    check_cnt++;
    if (u_tile0.frame !== 8'h00) $display("[TB] FAIL reset_held_high_no_shift: got %h required 00", u_tile0.frame);
    else pass_cnt++;
    scan_clk_in = 1'b0;
    repeat (PH) @(negedge clk);
    scan_cycle(1'b1, 1'b0, e, l);
    exp = exp_q.pop_front();
    model_sdo = exp;
    check_cnt++;
    if (u_tile0.frame !== model_frame)
      $display("[TB] FAIL reset_first_rise_shift: got %h required %h", u_tile0.frame, model_frame);
    else pass_cnt++;
  endtask

  task automatic test_shift();
    logic e, l, exp;
    logic [N-1:0] pat;
    do_reset();
    pat = 8'hC3;
    for (int i = N-1; i >= 0; i--) begin
      scan_cycle(pat[i], 1'b0, e, l);
      exp = exp_q.pop_front();
      model_sdo = exp;
      check_cnt++;
      if (l !== exp) $display("[TB] FAIL shift_sdo bit %0d: got %b required %b", i, l, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (u_tile0.frame !== 8'hC3) $display("[TB] FAIL shift_frame: got %h required c3", u_tile0.frame);
    else pass_cnt++;
  endtask

  task automatic test_capture();
    logic e, l, exp, prev;
    do_reset();
    module_data_out = 8'h5A;
    for (int i = 0; i <= N; i++) begin
      scan_cycle(1'b0, (i == 0), e, l);
      if (i == 0) begin
        check_cnt++;
        if (u_tile0.frame !== 8'h5A) $display("[TB] FAIL capture_frame: got %h required 5a", u_tile0.frame);
        else pass_cnt++;
      end
      prev = model_sdo;
      exp  = exp_q.pop_front();
      model_sdo = exp;
      check_cnt++;
      if (e !== prev) $display("[TB] FAIL capture_sdo_early %0d: got %b required %b", i, e, prev);
      else pass_cnt++;
      check_cnt++;
      if (l !== exp) $display("[TB] FAIL capture_sdo %0d: got %b required %b", i, l, exp);
      else pass_cnt++;
    end
    module_data_out = '0;
  endtask

  task automatic test_latch();
    logic e, l, exp;
    logic [N-1:0] pat;
    do_reset();
    pat = 8'h3C;
    for (int i = N-1; i >= 0; i--) begin
      scan_cycle(pat[i], 1'b0, e, l);
      exp = exp_q.pop_front();
      model_sdo = exp;
    end
    scan_latch_en_in = 1'b1;
    model_latch = model_frame;
    repeat (LAT-1) @(posedge clk);
    #1;
    check_cnt++;
    if (module_data_in !== 8'h00) $display("[TB] FAIL latch_not_early: got %h required 00", module_data_in);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (module_data_in !== model_latch) $display("[TB] FAIL latch_value: got %h required %h", module_data_in, model_latch);
    else pass_cnt++;
    repeat (PH) @(negedge clk);
    scan_latch_en_in = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      scan_cycle(1'b1, 1'b0, e, l);
      exp = exp_q.pop_front();
      model_sdo = exp;
    end
    check_cnt++;
    if (module_data_in !== 8'h3C) $display("[TB] FAIL latch_hold: got %h required 3c", module_data_in);
    else pass_cnt++;
    scan_data_in   = 1'b0;
    scan_select_in = 1'b0;
    repeat (PH) @(negedge clk);
    scan_clk_in      = 1'b1;
    scan_latch_en_in = 1'b1;
    model_latch = model_frame;
    model_frame = {model_frame[N-2:0], 1'b0};
    repeat (PH) @(negedge clk);
    check_cnt++;
    if (module_data_in !== model_latch)
      $display("[TB] FAIL latch_coincident_preshift: got %h required %h", module_data_in, model_latch);
    else pass_cnt++;
    check_cnt++;
    if (u_tile0.frame !== model_frame)
      $display("[TB] FAIL latch_coincident_frame: got %h required %h", u_tile0.frame, model_frame);
    else pass_cnt++;
    scan_clk_in      = 1'b0;
    scan_latch_en_in = 1'b0;
    model_sdo = model_frame[N-1];
    repeat (2*PH) @(negedge clk);
  endtask

  task automatic test_forwarding();
    logic prev_v, new_v, obs_e, obs_l;
    int   high_cnt, rise_cnt;
    logic last;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: begin prev_v = scan_select_in;   scan_select_in   = ~scan_select_in;   new_v = scan_select_in; end
        1: begin prev_v = scan_latch_en_in; scan_latch_en_in = ~scan_latch_en_in; new_v = scan_latch_en_in;
                 if (new_v) model_latch = model_frame; end
        default: begin prev_v = scan_clk_in; scan_clk_in = ~scan_clk_in; new_v = scan_clk_in;
                 if (new_v) model_frame = scan_select_in ? module_data_out : {model_frame[N-2:0], scan_data_in}; end
      endcase
      repeat (LAT-1) @(posedge clk);
      #1;
      case (k % 3)
        0: obs_e = scan_select_out;
        1: obs_e = scan_latch_en_out;
        default: obs_e = scan_clk_out;
      endcase
      @(posedge clk);
      #1;
      case (k % 3)
        0: obs_l = scan_select_out;
        1: obs_l = scan_latch_en_out;
        default: obs_l = scan_clk_out;
      endcase
      check_cnt++;
      if (obs_e !== prev_v) $display("[TB] FAIL fwd_early sig %0d: got %b required %b", k % 3, obs_e, prev_v);
      else pass_cnt++;
      check_cnt++;
      if (obs_l !== new_v) $display("[TB] FAIL fwd_latency sig %0d: got %b required %b", k % 3, obs_l, new_v);
      else pass_cnt++;
      repeat (PH) @(negedge clk);
    end
    check_cnt++;
    if (u_tile0.frame !== model_frame) $display("[TB] FAIL fwd_frame: got %h required %h", u_tile0.frame, model_frame);
    else pass_cnt++;
    scan_select_in = 1'b0;
    repeat (PH) @(negedge clk);
    high_cnt = 0;
    rise_cnt = 0;
    last     = scan_select_out;
    scan_select_in = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk);
        scan_select_in = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(posedge clk);
          #1;
          if (scan_select_out) high_cnt++;
          if (scan_select_out && !last) rise_cnt++;
          last = scan_select_out;
        end
      end
    join
    check_cnt++;
    if (high_cnt != 3 || rise_cnt != 1)
      $display("[TB] FAIL fwd_pulse: got %0d high cycles %0d rises required 3 high 1 rise", high_cnt, rise_cnt);
    else pass_cnt++;
  endtask

  task automatic test_chain();
    logic e, l, exp;
    logic [2*N-1:0] pat;
    int   lag_ok;
    do_reset();
    scan_select_in = 1'b1;
    repeat (PH) @(negedge clk);
    scan_clk_in = 1'b1;
    model_frame = module_data_out;
    repeat (2*LAT-1) @(posedge clk);
    #1 lag_ok = (t1_clk_out === 1'b0);
    @(posedge clk);
    #1;
    check_cnt++;
    if (lag_ok == 0 || t1_clk_out !== 1'b1)
      $display("[TB] FAIL chain_clk_lag: got early=%0d late=%b required early=1 late=1", lag_ok, t1_clk_out);
    else pass_cnt++;
    repeat (PH) @(negedge clk);
    scan_clk_in = 1'b0;
    model_sdo = model_frame[N-1];
    repeat (PH) @(negedge clk);
    pat = 16'hBEEF;
    for (int i = 2*N-1; i >= 0; i--) begin
      scan_cycle(pat[i], 1'b0, e, l);
      exp = exp_q.pop_front();
      model_sdo = exp;
      check_cnt++;
      if (l !== exp) $display("[TB] FAIL chain_sdo bit %0d: got %b required %b", i, l, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (u_tile0.frame !== 8'hEF) $display("[TB] FAIL chain_tile0_frame: got %h required ef", u_tile0.frame);
    else pass_cnt++;
    check_cnt++;
    if (u_tile1.frame !== 8'hBE) $display("[TB] FAIL chain_tile1_frame: got %h required be", u_tile1.frame);
    else pass_cnt++;
  endtask

  initial begin
    reset_n          = 1'b0;
    scan_clk_in      = 1'b0;
    scan_data_in     = 1'b0;
    scan_select_in   = 1'b0;
    scan_latch_en_in = 1'b0;
    module_data_out  = '0;
    model_frame      = '0;
    model_latch      = '0;
    model_sdo        = 1'b0;
    $display("[TB] scan_tile_responder bench start");
    test_reset();
    test_shift();
    test_capture();
    test_latch();
    test_forwarding();
    test_chain();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
